// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared width helper and per-channel reset defaults for the sequence detector
package seq_detect_pkg;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  localparam logic [31:0] DEF_PAT_A = 32'b010;
  localparam int DEF_LEN_A = 3;
  localparam logic [31:0] DEF_PAT_B = 32'b1001;
  localparam int DEF_LEN_B = 4;
endpackage

// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if: serial data, channel configuration and match/count signals
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
);
  import seq_detect_pkg::*;
  localparam int LEN_W = len_w(MAX_LEN);
  logic x;
  logic x_valid;
  logic cfg_wr;
  logic cfg_sel;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_overlap;
  logic cnt_clr;
  logic match_a;
  logic match_b;
  logic out;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  modport master (
    output x, x_valid, cfg_wr, cfg_sel, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input match_a, match_b, out, cnt_a, cnt_b
  );
  modport slave (
    input x, x_valid, cfg_wr, cfg_sel, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match_a, match_b, out, cnt_a, cnt_b
  );
endinterface

// File: rtl/seq_match_chan.sv
// seq_match_chan: one programmable detector channel with history, fill tracking and a saturating match counter
module seq_match_chan
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = len_w(MAX_LEN),
  parameter logic [31:0] DEF_PAT = DEF_PAT_A,
  parameter int DEF_LEN = DEF_LEN_A
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   cnt
);
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic overlap;
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic en;
  // Mealy match: newest len bits (history plus the bit arriving now) against the low pattern bits
  always_comb begin
    window = {hist, x};
    mask = ~({MAX_LEN{1'b1}} << len);
    en = len >= LEN_W'(2) && len <= LEN_W'(MAX_LEN);
    match = reset_n && x_valid && !wr && en && fill >= len - LEN_W'(1) && ((window ^ pattern) & mask) == '0;
  end
  // configuration, history and fill; a write discards the coincident bit, a non-overlap hit restarts fill
  always_ff @(posedge clk)
    if (!reset_n) begin
      pattern <= DEF_PAT[MAX_LEN-1:0];
      len <= LEN_W'(DEF_LEN);
      overlap <= 1'b1;
      hist <= '0;
      fill <= '0;
    end else if (wr) begin
      pattern <= cfg_pattern;
      len <= cfg_len;
      overlap <= cfg_overlap;
      fill <= '0;
    end else if (x_valid) begin
      hist <= window[MAX_LEN-2:0];
      fill <= (match && !overlap) ? '0 : (fill == LEN_W'(MAX_LEN - 1)) ? fill : fill + 1'b1;
    end
  // saturating match counter; clear beats a coincident increment
  always_ff @(posedge clk)
    if (!reset_n) cnt <= '0;
    else cnt <= cnt_clr ? '0 : (match && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: two independently programmable serial pattern detectors with combined match output
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset_n,
  seq_detect_prog_if.slave bus
);
  localparam int LEN_W = len_w(MAX_LEN);
  seq_match_chan #(
    .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W), .DEF_PAT(DEF_PAT_A), .DEF_LEN(DEF_LEN_A)
  ) u_a (
    .clk(clk),
    .reset_n(reset_n),
    .x(bus.x),
    .x_valid(bus.x_valid),
    .wr(bus.cfg_wr && !bus.cfg_sel),
    .cfg_pattern(bus.cfg_pattern),
    .cfg_len(bus.cfg_len),
    .cfg_overlap(bus.cfg_overlap),
    .cnt_clr(bus.cnt_clr),
    .match(bus.match_a),
    .cnt(bus.cnt_a)
  );
  seq_match_chan #(
    .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W), .DEF_PAT(DEF_PAT_B), .DEF_LEN(DEF_LEN_B)
  ) u_b (
    .clk(clk),
    .reset_n(reset_n),
    .x(bus.x),
    .x_valid(bus.x_valid),
    .wr(bus.cfg_wr && bus.cfg_sel),
    .cfg_pattern(bus.cfg_pattern),
    .cfg_len(bus.cfg_len),
    .cfg_overlap(bus.cfg_overlap),
    .cnt_clr(bus.cnt_clr),
    .match(bus.match_b),
    .cnt(bus.cnt_b)
  );
  assign bus.out = bus.match_a | bus.match_b;
endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, is the maximum pattern length in bits (legal 2..32).
REQ-002 Parameter CNT_W, default 8, is the width of each match counter.
REQ-003 Derived constant LEN_W = clog2(MAX_LEN+1), the width of the length fields.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  is the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 x  input  1  is the serial data bit.
REQ-007 x_valid  input  1  qualifies x; x is consumed only when x_valid=1.
REQ-008 cfg_wr  input  1  is a one-cycle configuration write strobe.
REQ-009 cfg_sel  input  1  selects the configured channel: 0=A, 1=B.
REQ-010 cfg_pattern  input  MAX_LEN  is the pattern; bit [len-1] is received first and bit [0] last.
REQ-011 cfg_len  input  LEN_W  is the pattern length.
REQ-012 cfg_overlap  input  1  selects detection mode: 1=overlapping, 0=non-overlapping.
REQ-013 cnt_clr  input  1  clears both match counters.
REQ-014 match_a, match_b  output  1  are the Mealy per-channel match flags.
REQ-015 out  output  1  is match_a OR match_b.
REQ-016 cnt_a, cnt_b  output  CNT_W  are the saturating match counts.

Function
REQ-017 The block SHALL contain two independent detector channels, A and B; each holds pattern, len, overlap, a history shift register of MAX_LEN-1 bits, and a fill counter.
REQ-018 On each cycle with x_valid=1 and no write to the channel, the channel SHALL shift x into history and increment fill, saturating at MAX_LEN-1.
REQ-019 match_x SHALL be combinational: x_valid=1, channel enabled, fill >= len-1, and {history[len-2:0], x} == pattern[len-1:0]; no cycle latency.
REQ-020 A channel is enabled only when 2 <= len <= MAX_LEN; a disabled channel SHALL never assert its match flag.
REQ-021 In overlapping mode, a match SHALL NOT disturb history or fill.
REQ-022 In non-overlapping mode, the cycle that matches SHALL set fill to 0 (history contents become don't-care).
REQ-023 cfg_wr SHALL load pattern, len and overlap into the selected channel and set its fill to 0; the other channel is unaffected.
REQ-024 If cfg_wr and x_valid occur together, x SHALL be discarded for the written channel, which does not assert match; the other channel processes x normally.
REQ-025 Each counter SHALL increment by 1 when its match flag is asserted, saturating at 2^CNT_W-1 without wrapping.
REQ-026 cnt_clr SHALL set both counters to 0 and SHALL win over a simultaneous match.
REQ-027 Pattern bits above len-1 SHALL be ignored.
REQ-028 Cycles with x_valid=0 SHALL hold all history, fill and counter state unchanged and keep match flags at 0.

Reset
REQ-029 When reset_n=0 at a clock edge, the block SHALL apply the following reset state:
- channel A: pattern = 3'b010, len = 3, overlap = 1;
- channel B: pattern = 4'b1001, len = 4, overlap = 1;
- all history bits, fill counters and counters = 0.
REQ-030 During and immediately after reset, match_a, match_b and out SHALL be 0 until fill qualifies; reset SHALL take priority over cfg_wr, cnt_clr and x_valid.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the LEN_W function and the default pattern and length constants for both channels.
REQ-032 Sub-module seq_match_chan SHALL implement one channel (config registers, history, fill, match, counter); the top instantiates it twice and ORs the match flags.

Verification
REQ-033 Scenario: after reset, stream 0,1,0,0,1 (x_valid=1) -> match_a on bit 3, match_b on bit 5, cnt_a=1, cnt_b=1.
REQ-034 Scenario: channel A in default overlap mode, stream 0,1,0,1,0 -> match_a on bits 3 and 5; write A with overlap=0, same stream -> match_a on bit 3 only.
REQ-035 Scenario: write A with pattern 8'b11010011, len=8, then stream that byte MSB-first -> match_a only on bit 8; an x_valid=0 gap mid-byte does not break the match.
REQ-036 Scenario: cfg_wr to B with cfg_len=1 or 9 -> B disabled, stream 1,0,0,1 gives no match_b; channel A unaffected.
REQ-037 Scenario: CNT_W=2 with 5 A-matches -> cnt_a stays at 3; cnt_clr coincident with a match -> cnt_a=0.
REQ-038 Scenario: reset_n=0 mid-pattern (after 1,0,0 on B), then 1 -> no match_b; the full 1,0,0,1 is required afterwards.
